// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-addressed 32-bit instruction memory with boot image
// Optional program-load port enabled by defining IM_LOAD_PORT_EN.
module instruction_memory #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
`ifdef IM_LOAD_PORT_EN
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
`endif
    output logic [31:0] instruction
);

    function automatic logic [31:0] boot_word(input logic [AW-1:0] idx);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (idx)
            AW'(0): w = 32'h2008_0005;
            AW'(1): w = 32'h2009_000A;
            AW'(2): w = 32'h0109_5020;
            AW'(3): w = 32'hAC0A_0000;
            AW'(4): w = 32'h8C0B_0000;
            AW'(5): w = 32'h0800_0000;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [AW-1:0] rd_idx;
    logic          rd_in_range;
    logic [31:0]   rd_word;

    assign rd_idx      = pc[AW+1:2];
    assign rd_in_range = (pc[31:AW+2] == '0);

`ifdef IM_LOAD_PORT_EN
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_idx;
    logic          wr_in_range;

    assign wr_idx      = load_addr[AW+1:2];
    assign wr_in_range = (load_addr[31:AW+2] == '0);

    // Reset reloads the whole image, so it also wipes any words written by the load port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= boot_word(AW'(i));
            end
        end else if (load_en && wr_in_range) begin
            mem_q[wr_idx] <= load_data;
        end
    end

    assign rd_word = mem_q[rd_idx];

    logic unused_bits;
    assign unused_bits = ^{pc[1:0], load_addr[1:0]};
`else
    assign rd_word = boot_word(rd_idx);

    logic unused_bits;
    assign unused_bits = ^{pc[1:0], clk};
`endif

    assign instruction = (rst || !rd_in_range) ? 32'h0000_0000 : rd_word;

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - table-driven self-checking bench for instruction_memory
module tb_instruction_memory;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
`ifdef IM_LOAD_PORT_EN
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
`endif

    int errors;
    int checks;

    instruction_memory #(.DEPTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
`ifdef IM_LOAD_PORT_EN
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
`endif
        .instruction (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] exp);
        checks++;
        if (instruction !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, instruction, exp);
        end
    endtask

    // Drive on the falling edge, check 1 ns later, then let the rising edge occur.
    task automatic apply(input logic r, input logic [31:0] p, input logic [31:0] exp, input string name);
        @(negedge clk);
        rst = r;
        pc  = p;
        #1;
        check(name, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        pc  = 32'h0;
`ifdef IM_LOAD_PORT_EN
        load_en   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
`endif

        vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0000, "reset_edge1"});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0000, "reset_edge2"});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h2008_0005, "fetch_00"});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h2009_000A, "fetch_04"});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0109_5020, "fetch_08"});
        vecs.push_back('{1'b0, 32'h0000_000C, 32'hAC0A_0000, "fetch_0c"});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h8C0B_0000, "fetch_10"});
        vecs.push_back('{1'b0, 32'h0000_0014, 32'h0800_0000, "fetch_14"});
        vecs.push_back('{1'b0, 32'h0000_0006, 32'h2009_000A, "misalign_06"});
        vecs.push_back('{1'b0, 32'h0000_0017, 32'h0800_0000, "misalign_17"});
        vecs.push_back('{1'b0, 32'h0000_0018, 32'h0000_0000, "zero_word_18"});
        vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0000_0000, "last_word_fc"});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0000_0000, "range_100"});
        vecs.push_back('{1'b0, 32'h0000_0108, 32'h0000_0000, "range_alias_108"});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, "range_fffc"});
        vecs.push_back('{1'b0, 32'h8000_0004, 32'h0000_0000, "range_msb"});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'h0000_0000, "reset_forces_zero"});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h2009_000A, "after_reset_04"});

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].pc, vecs[i].exp, vecs[i].name);
        end

        // Mid-run reset pulse at pc=0x0C.
        apply(1'b0, 32'h0000_000C, 32'hAC0A_0000, "midrun_before");
        apply(1'b1, 32'h0000_000C, 32'h0000_0000, "midrun_pulse");
        apply(1'b0, 32'h0000_000C, 32'hAC0A_0000, "midrun_after");

`ifdef IM_LOAD_PORT_EN
        // Write then read at 0x20: old word before the edge, new word after.
        @(negedge clk);
        pc        = 32'h0000_0020;
        load_en   = 1'b1;
        load_addr = 32'h0000_0020;
        load_data = 32'hDEAD_BEEF;
        #1 check("load_before_edge", 32'h0000_0000);
        @(posedge clk);
        #1 check("load_after_edge", 32'hDEAD_BEEF);
        @(negedge clk);
        load_en = 1'b0;

        // Misaligned load address writes the containing word.
        @(negedge clk);
        pc        = 32'h0000_0024;
        load_en   = 1'b1;
        load_addr = 32'h0000_0027;
        load_data = 32'h1234_5678;
        @(negedge clk);
        load_en = 1'b0;
        #1 check("load_misaligned", 32'h1234_5678);

        // Out-of-range load must not alias onto word 0.
        @(negedge clk);
        pc        = 32'h0000_0000;
        load_en   = 1'b1;
        load_addr = 32'h0000_0100;
        load_data = 32'hFFFF_FFFF;
        @(negedge clk);
        load_en = 1'b0;
        #1 check("load_oor_dropped", 32'h2008_0005);

        // Reset and load on the same edge: reset wins.
        @(negedge clk);
        rst       = 1'b1;
        pc        = 32'h0000_0000;
        load_en   = 1'b1;
        load_addr = 32'h0000_0000;
        load_data = 32'hCAFE_F00D;
        #1 check("prio_during_reset", 32'h0000_0000);
        @(negedge clk);
        rst     = 1'b0;
        load_en = 1'b0;
        #1 check("prio_reset_wins", 32'h2008_0005);
        pc = 32'h0000_0020;
        #1 check("reset_clears_loaded", 32'h0000_0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
